// File: rtl/acq_buffer_core_if.sv
// Register-bus port bundle for acq_buffer_core: the host drives the master side,
// the buffer core implements the slave side.
interface acq_buffer_core_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/acq_buffer_core.sv
// Circular acquisition buffer with pretrigger, trigger capture and indirect ADDR/DATA readout.
// Optional software trigger (CSR bit3) is built when ACQ_BUF_SW_TRIGGER_EN is defined.
module acq_buffer_core #(
  parameter int unsigned g_data_width = 16,
  parameter int unsigned g_size_log2  = 11
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic [g_data_width-1:0] data_i,
  input  logic                    valid_i,
  input  logic                    trigger_i,
  acq_buffer_core_if.slave        wb
);

  localparam int unsigned L     = g_size_log2;
  localparam int unsigned DEPTH = 1 << L;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [L-1:0]      wptr_q, wptr_d;
  logic [L-1:0]      pre_cnt_q, pre_cnt_d;
  logic [L-1:0]      post_cnt_q, post_cnt_d;
  logic [L-1:0]      pretrig_q, pretrig_d;
  logic [L-1:0]      pretrig_act_q, pretrig_act_d;
  logic [L-1:0]      trig_pos_q, trig_pos_d;
  logic [L-1:0]      addr_q, addr_d;
  logic              ack_q, ack_d;
  logic              rd_pend_q, rd_pend_d;
  logic [31:0]       dat_q, dat_d;

  logic [g_data_width-1:0] mem [DEPTH];
  logic [g_data_width-1:0] ram_q;

  logic       acc, wr, start, mem_we, sw_trig, ready, busy;
  logic [2:0] sel;
  logic       unused_bits;

  assign sel   = wb.wb_adr_i[4:2];
  assign acc   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~rd_pend_q;
  assign wr    = acc & wb.wb_we_i;
  assign start = wr & (sel == 3'd0) & wb.wb_dat_i[0];
  assign ready = (state_q == S_DONE);
  assign busy  = (state_q == S_PRE) | (state_q == S_ARMED) | (state_q == S_POST);

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_dat_i};

`ifdef ACQ_BUF_SW_TRIGGER_EN
  logic sw_pend_q, sw_pend_d;

  // A pending software trigger survives only while ARMED and is consumed by the next valid sample.
  always_comb begin
    sw_pend_d = sw_pend_q;
    if (state_q != S_ARMED || start || valid_i) sw_pend_d = 1'b0;
    if (wr && sel == 3'd0 && wb.wb_dat_i[3] && state_q == S_ARMED && !start) sw_pend_d = 1'b1;
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) sw_pend_q <= 1'b0;
    else          sw_pend_q <= sw_pend_d;
  end

  assign sw_trig = sw_pend_q;
`else
  assign sw_trig = 1'b0;
`endif

  always_comb begin
    ack_d     = (acc & ~(~wb.wb_we_i & (sel == 3'd5))) | rd_pend_q;
    rd_pend_d = acc & ~wb.wb_we_i & (sel == 3'd5);
    dat_d     = '0;
    pretrig_d = pretrig_q;
    addr_d    = addr_q;
    if (rd_pend_q) begin
      dat_d = 32'(ram_q);
    end else if (acc && !wb.wb_we_i) begin
      case (sel)
        3'd0:    dat_d = {28'd0, sw_trig, busy, ready, 1'b0};
        3'd1:    dat_d = 32'(pretrig_q);
        3'd2:    dat_d = 32'(DEPTH);
        3'd3:    dat_d = 32'(trig_pos_q);
        3'd4:    dat_d = 32'(addr_q);
        default: dat_d = '0;
      endcase
    end
    if (wr && sel == 3'd1) begin
      if (|wb.wb_dat_i[31:L]) pretrig_d = '1;
      else                    pretrig_d = wb.wb_dat_i[L-1:0];
    end
    if (wr && sel == 3'd4) addr_d = wb.wb_dat_i[L-1:0];
  end

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    pre_cnt_d     = pre_cnt_q;
    post_cnt_d    = post_cnt_q;
    pretrig_act_d = pretrig_act_q;
    trig_pos_d    = trig_pos_q;
    mem_we        = 1'b0;
    case (state_q)
      S_PRE: begin
        if (valid_i) begin
          mem_we    = 1'b1;
          wptr_d    = wptr_q + 1'b1;
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
        if (pre_cnt_q == pretrig_act_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (valid_i) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (trigger_i || sw_trig) begin
            trig_pos_d = wptr_q;
            post_cnt_d = {L{1'b1}} - pretrig_act_q;
            state_d    = (pretrig_act_q == {L{1'b1}}) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (valid_i) begin
          mem_we     = 1'b1;
          wptr_d     = wptr_q + 1'b1;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == {{(L-1){1'b0}}, 1'b1}) state_d = S_DONE;
        end
      end
      default: ;
    endcase
    // START overrides whatever the current record was doing, including mid-POST.
    if (start) begin
      state_d       = S_PRE;
      wptr_d        = '0;
      pre_cnt_d     = '0;
      pretrig_act_d = pretrig_q;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      wptr_q        <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      pretrig_q     <= '0;
      pretrig_act_q <= '0;
      trig_pos_q    <= '0;
      addr_q        <= '0;
      ack_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      dat_q         <= '0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      pre_cnt_q     <= pre_cnt_d;
      post_cnt_q    <= post_cnt_d;
      pretrig_q     <= pretrig_d;
      pretrig_act_q <= pretrig_act_d;
      trig_pos_q    <= trig_pos_d;
      addr_q        <= addr_d;
      ack_q         <= ack_d;
      rd_pend_q     <= rd_pend_d;
      dat_q         <= dat_d;
    end
  end

  // Port A: sample write; port B: continuous read of mem[ADDR] feeding DATA reads.
  always_ff @(posedge clk_sys_i) begin
    if (mem_we) mem[wptr_q] <= data_i;
    ram_q <= mem[addr_q];
  end

endmodule

// File: tb/tb_acq_buffer_core.sv
// Directed bench for acq_buffer_core: register access, record capture, abort, wrap and reset.
module tb_acq_buffer_core;

  localparam logic [4:0] A_CSR  = 5'h00;
  localparam logic [4:0] A_PRE  = 5'h04;
  localparam logic [4:0] A_SIZE = 5'h08;
  localparam logic [4:0] A_TP   = 5'h0C;
  localparam logic [4:0] A_ADDR = 5'h10;
  localparam logic [4:0] A_DATA = 5'h14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic        valid = 1'b0;
  logic        trig = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  int          base = 0;
  int          t1 = -1;
  int          t2 = -1;
  logic [15:0] dofs = '0;
  bit          stream_en = 1'b0;

  always #5 clk = ~clk;

  acq_buffer_core_if bus_if ();

  acq_buffer_core #(.g_data_width(16), .g_size_log2(11)) dut (
    .clk_sys_i (clk),
    .rst_n_i   (rst_n),
    .data_i    (data),
    .valid_i   (valid),
    .trigger_i (trig),
    .wb        (bus_if.slave)
  );

  // Sample n of the current record is presented at the n-th edge after the START ack.
  always @(posedge clk) begin
    cyc_cnt++;
    #2;
    if (stream_en) begin
      data  = dofs + 16'(cyc_cnt - base);
      valid = 1'b1;
      trig  = ((cyc_cnt - base) == t1) || ((cyc_cnt - base) == t2);
    end else begin
      valid = 1'b0;
      trig  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] q, output int lat);
    @(posedge clk); #1;
    bus_if.wb_adr_i = a;
    bus_if.wb_dat_i = d;
    bus_if.wb_we_i  = w;
    bus_if.wb_cyc_i = 1'b1;
    bus_if.wb_stb_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_if.wb_ack_o && lat < 8);
    q = bus_if.wb_dat_o;
    if (!bus_if.wb_ack_o) chk("ack_timeout", {31'd0, bus_if.wb_ack_o}, 32'd1);
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] q;
    int l;
    bus(1'b1, a, d, q, l);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] q);
    int l;
    bus(1'b0, a, 32'd0, q, l);
  endtask

  task automatic start_rec(input logic [31:0] pre, input int tt1, input int tt2, input logic [15:0] off);
    wr(A_PRE, pre);
    t1 = tt1;
    t2 = tt2;
    dofs = off;
    wr(A_CSR, 32'h1);
    base = cyc_cnt;
    stream_en = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    logic [31:0] q;
    int n;
    n = 0;
    do begin
      rd(A_CSR, q);
      n++;
    end while (!q[1] && n < 3000);
    chk(tag, {31'd0, q[1]}, 32'd1);
    stream_en = 1'b0;
  endtask

  logic [31:0] q;
  int          lat;

  initial begin
    bus_if.wb_adr_i = '0;
    bus_if.wb_dat_i = '0;
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, bus_if.wb_ack_o}, 32'd0);
    chk("rst_dat", bus_if.wb_dat_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    bus(1'b0, A_SIZE, 32'd0, q, lat);
    chk("size", q, 32'd2048);
    chk("size_lat", 32'(lat), 32'd1);
    rd(A_CSR, q);  chk("rst_csr", q, 32'd0);
    rd(A_PRE, q);  chk("rst_pre", q, 32'd0);
    rd(A_ADDR, q); chk("rst_addr", q, 32'd0);
    rd(A_TP, q);   chk("rst_tp", q, 32'd0);
    wr(A_SIZE, 32'd5);
    rd(A_SIZE, q); chk("size_ro", q, 32'd2048);

    // Record 1: ramp, pretrigger 300, trigger at sample 1000.
    start_rec(32'd300, 1000, -1, 16'h0000);
    rd(A_CSR, q); chk("rec1_busy", q, 32'h4);
    wait_ready("rec1_ready");
    rd(A_CSR, q); chk("rec1_csr", q, 32'h2);
    rd(A_TP, q);  chk("rec1_tp", q, 32'd1000);
    for (int i = 0; i < 1024; i++) begin
      wr(A_ADDR, 32'((i - 300 + 1000) & 2047));
      rd(A_DATA, q);
      chk("rec1_data", q, 32'(700 + i));
    end

    // Record 2: trigger during PRE ignored, later trigger captured.
    start_rec(32'd300, 100, 500, 16'h4000);
    wait_ready("rec2_ready");
    rd(A_TP, q); chk("rec2_tp", q, 32'd500);
    wr(A_ADDR, 32'd500); rd(A_DATA, q); chk("rec2_trig_sample", q, 32'h41F4);
    wr(A_ADDR, 32'd200); rd(A_DATA, q); chk("rec2_pre_sample", q, 32'h40C8);

    // Record 3 aborted mid-POST by a new START; record 4 completes.
    start_rec(32'd300, 400, -1, 16'h3000);
    repeat (700) @(posedge clk);
    rd(A_CSR, q); chk("abort_post_busy", q, 32'h4);
    t1 = 800;
    dofs = 16'h2000;
    wr(A_CSR, 32'h1);
    base = cyc_cnt;
    rd(A_CSR, q); chk("abort_not_ready", q, 32'h4);
    wait_ready("rec4_ready");
    rd(A_TP, q); chk("rec4_tp", q, 32'd800);
    wr(A_ADDR, 32'd800); rd(A_DATA, q); chk("rec4_trig_sample", q, 32'h2320);
    wr(A_ADDR, 32'd100); rd(A_DATA, q); chk("rec4_wrapped", q, 32'h2864);

    // ADDR masking and DATA latency.
    wr(A_ADDR, 32'hFFFFF);
    rd(A_ADDR, q); chk("addr_mask", q, 32'h7FF);
    bus(1'b0, A_DATA, 32'd0, q, lat);
    chk("data_2047", q, 32'h27FF);
    chk("data_lat", 32'(lat), 32'd2);
    wr(A_ADDR, 32'hFFFFFFFF);
    rd(A_DATA, q); chk("data_neg1", q, 32'h27FF);

    // PRETRIGGER clamp: post-count zero, DONE directly on trigger.
    wr(A_PRE, 32'd5000);
    rd(A_PRE, q); chk("pre_clamp", q, 32'h7FF);
    start_rec(32'd5000, 2100, -1, 16'h0000);
    wait_ready("clamp_ready");
    rd(A_TP, q); chk("clamp_tp", q, 32'd52);
    wr(A_ADDR, 32'd52); rd(A_DATA, q); chk("clamp_sample", q, 32'h834);

    // Software trigger.
    start_rec(32'd0, -1, -1, 16'h0000);
    repeat (3) @(posedge clk);
    wr(A_CSR, 32'h8);
`ifdef ACQ_BUF_SW_TRIGGER_EN
    wait_ready("swtrig_ready");
`else
    repeat (2200) @(posedge clk);
    rd(A_CSR, q); chk("swtrig_ignored", q, 32'h4);
    stream_en = 1'b0;
`endif

    // Reset during an acquisition.
    start_rec(32'd300, 350, -1, 16'h0000);
    repeat (500) @(posedge clk);
    rst_n = 1'b0;
    #3;
    chk("midrst_ack", {31'd0, bus_if.wb_ack_o}, 32'd0);
    stream_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_CSR, q); chk("midrst_csr", q, 32'd0);
    rd(A_TP, q);  chk("midrst_tp", q, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
